aes_key_expand_iter: RTL and testbench
======================================

AES_KEY_EXPAND_ITER -- requirements
Module: aes_key_expand_iter

Interface
REQ-001 The module SHALL have no parameters; the key size SHALL be fixed at 128 bits.
REQ-002 clk  in  1  Single clock; all state SHALL update on the rising edge.
REQ-003 nreset  in  1  Reset, asynchronous and active-low.
REQ-004 start_i  in  1  Request expansion of key_i; sampled only in IDLE.
REQ-005 key_i  in  128  Cipher key; FIPS-197 byte n SHALL be at [8n+7:8n], word i at [32i+31:32i].
REQ-006 ready_i  in  1  Consumer accepts the round key offered on rkey_o.
REQ-007 rkey_v_o  out  1  Round key valid.
REQ-008 rkey_o  out  128  Current round key, same packing as key_i.
REQ-009 round_o  out  4  Index of rkey_o, 0..10.
REQ-010 busy_o  out  1  High in RUN.
REQ-011 done_o  out  1  Single-cycle pulse on acceptance of round 10.
REQ-012 last_key_o  out  128  Round-10 key, held until the next start; this is the seed for the inverse schedule.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN; IDLE->RUN on start_i=1; RUN->IDLE on acceptance (rkey_v_o & ready_i) with round_o=10.
REQ-014 On the start edge: key_i SHALL be captured, round_o=0, rcon=8'h01, rkey_v_o=1 in the next cycle with rkey_o=key_i.
REQ-015 Each acceptance with round_o<10 SHALL load the next round key on that edge, so a new key is valid the following cycle; round_o increments by 1.
REQ-016 Next key: t = SubWord(RotWord(w3)) ^ {24'h0, rcon}, with RotWord moving byte1->byte0, byte2->byte1, byte3->byte2, byte0->byte3.
REQ-017 Next key: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-018 rcon SHALL update per step: rcon[7] ? 8'h1b : rcon<<1 (01,02,...,80,1b,36).
REQ-019 With ready_i=0, rkey_o, round_o and rkey_v_o SHALL hold stable; the stall length is unbounded.
REQ-020 With ready_i held at 1, rounds 0..10 SHALL appear on 11 consecutive cycles: start at T, round 0 at T+1, round 10 at T+11, done_o at T+11.
REQ-021 last_key_o SHALL be written when round 10 is loaded.
REQ-022 start_i in RUN SHALL be ignored.
REQ-023 start_i in the cycle after the return to IDLE SHALL be honoured.
REQ-024 The S-box SHALL be combinational, reusing the existing aes_sbox, 4 instances; no extra pipeline stage.

Reset
REQ-025 nreset=0 SHALL force IDLE and rkey_v_o=0, busy_o=0, done_o=0, round_o=0, rkey_o=0, last_key_o=0, rcon=8'h01 without waiting for clk.
REQ-026 Reset mid-RUN SHALL abandon the expansion; no done_o SHALL follow.

Configuration
REQ-027 Macro AES_KEY_EXPAND_STORE_EN defined: the block SHALL add an 11x128 store written with each loaded round key.
REQ-028 With the store, the block SHALL add ports rd_idx_i (in, 4) and rd_key_o (out, 128).
REQ-029 rd_key_o SHALL be combinational from rd_idx_i; an index >10 SHALL read 0; the store SHALL clear on reset.
REQ-030 Macro undefined: these ports and the store SHALL be absent, with all other behaviour identical.

Verification
REQ-031 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ready_i=1 -> round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11, done_o=1 at T+11 only.
REQ-032 Same key, ready_i=0 for 5 cycles at round 3 -> rkey_o = 3d80477d4716fe3e1e237e446d7a883b held stable; round 4 appears one cycle after ready_i rises.
REQ-033 Zero key -> rcon sequence 01..36 is observed (internal probe); round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 start_i pulsed at round 5 with a different key -> ignored, original sequence completes; start on the cycle after done_o -> new run begins.
REQ-035 nreset asserted mid-round 6 -> all outputs 0 immediately, no done_o; a fresh start afterwards reproduces REQ-031.
REQ-036 AES_KEY_EXPAND_STORE_EN defined, after REQ-031 -> rd_idx_i=0 returns the key, 10 returns d014...0ca6, 12 returns 0.

Source files
------------

// File: rtl/aes_key_expand_iter.sv
`default_nettype none
// ============================================================================
// aes_key_expand_iter : iterative AES-128 key schedule, one round key per
// accepted handshake, with a combinational 4-way S-box on the w3 path.
// Optional round-key store enabled by `define AES_KEY_EXPAND_STORE_EN.
// Revision: 1.0
// ============================================================================

module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_p2, w_p4, w_p8, w_p16, w_p32, w_p64, w_p128, w_inv;

    // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
    always_comb begin
        w_p2   = gf_mul(byte_i, byte_i);
        w_p4   = gf_mul(w_p2, w_p2);
        w_p8   = gf_mul(w_p4, w_p4);
        w_p16  = gf_mul(w_p8, w_p8);
        w_p32  = gf_mul(w_p16, w_p16);
        w_p64  = gf_mul(w_p32, w_p32);
        w_p128 = gf_mul(w_p64, w_p64);
        w_inv  = gf_mul(gf_mul(gf_mul(w_p2, w_p4), gf_mul(w_p8, w_p16)),
                        gf_mul(gf_mul(w_p32, w_p64), w_p128));
        byte_o = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand_iter (
    input  logic         clk,
    input  logic         nreset,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         ready_i,
`ifdef AES_KEY_EXPAND_STORE_EN
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_key_o,
`endif
    output logic         rkey_v_o,
    output logic [127:0] rkey_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] last_key_o
);
    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] RUN        = 1'b1;
    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    logic [0:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] last_key_q, last_key_d;

    logic         w_accept, w_start, w_step, w_load;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_nw0, w_nw1, w_nw2, w_nw3;
    logic [127:0] w_next_key;

    // RotWord in byte-0-first packing: byte1->byte0 ... byte0->byte3.
    assign w_rot = {key_q[103:96], key_q[127:104]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .byte_i (w_rot[8*gi +: 8]),
                .byte_o (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_t        = w_sub ^ {24'h0, rcon_q};
        w_nw0      = key_q[31:0]   ^ w_t;
        w_nw1      = key_q[63:32]  ^ w_nw0;
        w_nw2      = key_q[95:64]  ^ w_nw1;
        w_nw3      = key_q[127:96] ^ w_nw2;
        w_next_key = {w_nw3, w_nw2, w_nw1, w_nw0};
    end

    always_comb begin
        w_accept = (state_q == RUN) && ready_i;
        w_start  = (state_q == IDLE) && start_i;
        w_step   = w_accept && (round_q != LAST_ROUND);
        w_load   = w_start || w_step;

        state_d    = state_q;
        key_d      = key_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        last_key_d = last_key_q;

        if (w_load) key_d = w_start ? key_i : w_next_key;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    round_d = 4'd0;
                    rcon_d  = RCON_INIT;
                end
            end
            RUN: begin
                if (ready_i) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                    end else begin
                        round_d = round_q + 4'd1;
                        rcon_d  = rcon_q[7] ? 8'h1b : {rcon_q[6:0], 1'b0};
                        if (round_q == LAST_ROUND - 4'd1) last_key_d = w_next_key;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            key_q      <= '0;
            round_q    <= 4'd0;
            rcon_q     <= RCON_INIT;
            last_key_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            last_key_q <= last_key_d;
        end
    end

    assign rkey_v_o   = (state_q == RUN);
    assign busy_o     = (state_q == RUN);
    assign done_o     = w_accept && (round_q == LAST_ROUND);
    assign rkey_o     = key_q;
    assign round_o    = round_q;
    assign last_key_o = last_key_q;

`ifdef AES_KEY_EXPAND_STORE_EN
    logic [127:0] store_q [0:10];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 11; i++) store_q[i] <= '0;
        end else if (w_load) begin
            store_q[round_d] <= key_d;
        end
    end

    assign rd_key_o = (rd_idx_i <= LAST_ROUND) ? store_q[rd_idx_i] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand_iter.sv
`default_nettype none
// ============================================================================
// tb_aes_key_expand_iter : FIPS-197 vectors, stall/restart/reset scenarios and
// random traffic, checked every cycle against a word-level key schedule model.
// Revision: 1.0
// ============================================================================
module tb_aes_key_expand_iter;
    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         ready_i = 1'b0;
    logic         rkey_v_o, busy_o, done_o;
    logic [127:0] rkey_o, last_key_o;
    logic [3:0]   round_o;
`ifdef AES_KEY_EXPAND_STORE_EN
    logic [3:0]   rd_idx_i = 4'd0;
    logic [127:0] rd_key_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aes_key_expand_iter dut (
        .clk        (clk),
        .nreset     (nreset),
        .start_i    (start_i),
        .key_i      (key_i),
        .ready_i    (ready_i),
`ifdef AES_KEY_EXPAND_STORE_EN
        .rd_idx_i   (rd_idx_i),
        .rd_key_o   (rd_key_o),
`endif
        .rkey_v_o   (rkey_v_o),
        .rkey_o     (rkey_o),
        .round_o    (round_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .last_key_o (last_key_o)
    );

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int j = 15; j >= 8; j--) if (p[j]) p = p ^ (16'h011b << (j - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv, s, c;
        inv = 8'h00;
        c   = 8'h63;
        if (a != 8'h00)
            for (int x = 1; x < 256; x++)
                if (gf_mul_ref(a, 8'(x)) == 8'h01) inv = 8'(x);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [7:0] rcon_of(input int n);
        int v;
        v = 1;
        repeat (n) begin
            v = v << 1;
            if (v > 255) v = v ^ 32'h11b;
        end
        return 8'(v);
    endfunction

    function automatic logic [127:0] key_round(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {24'h0, rcon_of(i/4 - 1)};
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endfunction

    // FIPS hex strings list byte 0 first; the port packs byte 0 at [7:0].
    function automatic logic [127:0] fips(input logic [127:0] h);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = h[127-8*n -: 8];
        return r;
    endfunction

    logic         m_run = 1'b0;
    logic [3:0]   m_round = 4'd0;
    logic [127:0] m_last = '0;
    logic [127:0] m_keys [11];
    logic [127:0] m_store [11];

    initial for (int r = 0; r < 11; r++) begin m_keys[r] = '0; m_store[r] = '0; end

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_run   <= 1'b0;
            m_round <= 4'd0;
            m_last  <= '0;
            for (int r = 0; r < 11; r++) begin m_keys[r] <= '0; m_store[r] <= '0; end
        end else if (!m_run) begin
            if (start_i) begin
                for (int r = 0; r < 11; r++) m_keys[r] <= key_round(key_i, r);
                m_run      <= 1'b1;
                m_round    <= 4'd0;
                m_store[0] <= key_i;
            end
        end else if (ready_i) begin
            if (m_round == 4'd10) begin
                m_run <= 1'b0;
            end else begin
                m_round <= m_round + 4'd1;
                m_store[m_round + 4'd1] <= m_keys[m_round + 4'd1];
                if (m_round == 4'd9) m_last <= m_keys[10];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("rkey_v", 128'(rkey_v_o), 128'(m_run));
        check("busy", 128'(busy_o), 128'(m_run));
        check("done", 128'(done_o), 128'(m_run && ready_i && (m_round == 4'd10)));
        check("round", 128'(round_o), 128'(m_round));
        check("rkey", rkey_o, m_keys[m_round]);
        check("last_key", last_key_o, m_last);
        if (m_run && m_round < 4'd10) check("rcon", 128'(dut.rcon_q), 128'(rcon_of(int'(m_round))));
`ifdef AES_KEY_EXPAND_STORE_EN
        check("rd_key", rd_key_o, (rd_idx_i <= 4'd10) ? m_store[rd_idx_i] : 128'h0);
`endif
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1     = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R3     = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] R10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZR10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input logic [127:0] k);
        key_i   = k;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            cycles++;
            if (done_o) found = 1'b1;
        end
        if (!found) check("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (round_o == r && busy_o) found = 1'b1;
            else tick();
        end
        if (!found) check("round_timeout", 128'd0, 128'd1);
    endtask

    int c;
    logic [127:0] k2;

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_ref(8'(i));

        // Pin the model against published vectors.
        check("model_sbox_00", 128'(sbox_t[0]), 128'h63);
        check("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        check("model_r1", key_round(fips(K_FIPS), 1), fips(R1));
        check("model_r3", key_round(fips(K_FIPS), 3), fips(R3));
        check("model_r10", key_round(fips(K_FIPS), 10), fips(R10));
        check("model_zero_r10", key_round('0, 10), fips(ZR10));

        repeat (2) tick();
        check("reset_rkey_v", 128'(rkey_v_o), 128'd0);
        check("reset_rkey", rkey_o, 128'd0);
        check("reset_rcon", 128'(dut.rcon_q), 128'h01);
        nreset = 1'b1;
        tick();

        // Full-rate run: round 10 on the 11th cycle after start.
        ready_i = 1'b1;
        start_run(fips(K_FIPS));
        check("first_round_key", rkey_o, fips(K_FIPS));
        wait_done(c);
        check("latency_to_done", 128'(c), 128'd11);
        check("done_round_key", rkey_o, fips(R10));
        tick();
        check("last_key_fips", last_key_o, fips(R10));
`ifdef AES_KEY_EXPAND_STORE_EN
        rd_idx_i = 4'd0;  #1 check("store_idx0", rd_key_o, fips(K_FIPS));
        rd_idx_i = 4'd10; #1 check("store_idx10", rd_key_o, fips(R10));
        rd_idx_i = 4'd12; #1 check("store_idx12", rd_key_o, 128'h0);
        rd_idx_i = 4'd0;
`endif

        // Stall at round 3 for five cycles.
        start_run(fips(K_FIPS));
        wait_round(4'd3);
        ready_i = 1'b0;
        repeat (5) begin
            tick();
            check("stall_key", rkey_o, fips(R3));
            check("stall_round", 128'(round_o), 128'd3);
        end
        ready_i = 1'b1;
        tick();
        check("post_stall_round", 128'(round_o), 128'd4);
        wait_done(c);
        tick();

        // Zero key.
        start_run('0);
        wait_done(c);
        tick();
        check("last_key_zero", last_key_o, fips(ZR10));

        // start_i in RUN ignored; start right after the return to IDLE honoured.
        start_run(fips(K_FIPS));
        wait_round(4'd5);
        key_i   = ~fips(K_FIPS);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(c);
        check("ignored_start_last", rkey_o, fips(R10));
        tick();
        k2 = {$urandom, $urandom, $urandom, $urandom};
        start_run(k2);
        check("restart_busy", 128'(busy_o), 128'd1);
        check("restart_key", rkey_o, k2);
        wait_done(c);
        tick();
        check("restart_last", last_key_o, key_round(k2, 10));

        // Reset mid round 6.
        start_run(fips(K_FIPS));
        wait_round(4'd6);
        nreset = 1'b0;
        #1;
        check("rst_rkey_v", 128'(rkey_v_o), 128'd0);
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_done", 128'(done_o), 128'd0);
        check("rst_round", 128'(round_o), 128'd0);
        check("rst_rkey", rkey_o, 128'd0);
        check("rst_last", last_key_o, 128'd0);
        repeat (2) tick();
        nreset = 1'b1;
        tick();
        start_run(fips(K_FIPS));
        wait_done(c);
        check("post_reset_latency", 128'(c), 128'd11);
        tick();
        check("post_reset_last", last_key_o, fips(R10));

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            start_i = ($urandom % 8) == 0;
            key_i   = {$urandom, $urandom, $urandom, $urandom};
            ready_i = ($urandom % 4) != 0;
            nreset  = ($urandom % 300) != 0;
`ifdef AES_KEY_EXPAND_STORE_EN
            rd_idx_i = 4'($urandom % 16);
`endif
            tick();
        end
        nreset  = 1'b1;
        start_i = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
